// File: rtl/cv32e40p_if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// cv32e40p_if_prefetch_stage
//
// Instruction-fetch stage with a prefetch FIFO in front of the IF/ID
// register. It talks to instruction memory over a pipelined
// req/gnt/rvalid interface and keeps up to MAX_OUTSTANDING fetches in
// flight. A redirect (pc_set_i) flushes the FIFO and arms a discard counter
// so that late responses from the old stream never reach ID.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   pc_set_i              redirect fetch to branch_addr_i (word aligned here)
//   branch_addr_i         new fetch target, already selected upstream
//   instr_req_o           fetch request
//   instr_addr_o          fetch address, held until granted
//   instr_gnt_i           request accepted this cycle
//   instr_rvalid_i        in-order response valid
//   instr_rdata_i         response data
//   halt_if_i             stall requests and IF/ID loads
//   id_ready_i            ID accepts a new instruction
//   clear_instr_valid_i   invalidate the IF/ID entry
//   instr_valid_id_o      IF/ID entry valid
//   instr_rdata_id_o      IF/ID instruction word
//   pc_id_o               IF/ID program counter
//   fifo_count_o          number of buffered {pc, instr} entries
//   busy_o                fetches still in flight (live or being discarded)
// ---------------------------------------------------------------------------
module cv32e40p_if_prefetch_stage #(
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0080
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pc_set_i,
  input  logic [31:0]                     branch_addr_i,
  output logic                            instr_req_o,
  output logic [31:0]                     instr_addr_o,
  input  logic                            instr_gnt_i,
  input  logic                            instr_rvalid_i,
  input  logic [31:0]                     instr_rdata_i,
  input  logic                            halt_if_i,
  input  logic                            id_ready_i,
  input  logic                            clear_instr_valid_i,
  output logic                            instr_valid_id_o,
  output logic [31:0]                     instr_rdata_id_o,
  output logic [31:0]                     pc_id_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count_o,
  output logic                            busy_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;

  // Fetch-side state
  logic [31:0]      fetch_addr_p0;
  logic [31:0]      resp_pc_p0;
  logic [CNT_W-1:0] outstanding_p0;
  logic [CNT_W-1:0] discard_cnt_p0;

  // Prefetch FIFO
  logic [31:0]      fifo_pc_p0    [FIFO_DEPTH];
  logic [31:0]      fifo_instr_p0 [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_p0;
  logic [PTR_W-1:0] wr_ptr_p0;
  logic [CNT_W-1:0] count_p0;

  // IF/ID register
  logic             vld_p1;
  logic [31:0]      instr_p1;
  logic [31:0]      pc_p1;

  logic             req;
  logic             fire;
  logic             rsp;
  logic             push;
  logic             pop;
  logic             load;
  logic [SUM_W-1:0] live_entries;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [31:0]      branch_aligned;
  logic             unused_branch_lsb;

  assign branch_aligned    = {branch_addr_i[31:2], 2'b00};
  assign unused_branch_lsb = ^branch_addr_i[1:0];

  // Slots already claimed in the FIFO: buffered words plus fetches whose
  // responses will be kept. Stale fetches do not occupy a slot.
  assign live_entries = {1'b0, count_p0} + {1'b0, outstanding_p0} - {1'b0, discard_cnt_p0};

  assign req  = ~rst & ~halt_if_i
              & (outstanding_p0 < CNT_W'(MAX_OUTSTANDING))
              & (live_entries < SUM_W'(FIFO_DEPTH));
  assign fire = req & instr_gnt_i;
  // A response with nothing in flight is a protocol violation and is ignored.
  assign rsp  = instr_rvalid_i & (outstanding_p0 != '0);
  assign push = rsp & (discard_cnt_p0 == '0) & ~pc_set_i;
  assign load = ~halt_if_i & id_ready_i;
  assign pop  = load & (count_p0 != '0) & ~pc_set_i;

  assign outstanding_nxt = outstanding_p0 + CNT_W'(fire) - CNT_W'(rsp);
  assign count_nxt       = count_p0 + CNT_W'(push) - CNT_W'(pop);

  assign instr_req_o      = req;
  assign instr_addr_o     = fetch_addr_p0;
  assign instr_valid_id_o = vld_p1;
  assign instr_rdata_id_o = instr_p1;
  assign pc_id_o          = pc_p1;
  assign fifo_count_o     = count_p0;
  assign busy_o           = (outstanding_p0 != '0) | (discard_cnt_p0 != '0);

  // ---- p0: fetch control and FIFO bookkeeping ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_addr_p0  <= RESET_PC;
      resp_pc_p0     <= RESET_PC;
      outstanding_p0 <= '0;
      discard_cnt_p0 <= '0;
      rd_ptr_p0      <= '0;
      wr_ptr_p0      <= '0;
      count_p0       <= '0;
    end else begin
      outstanding_p0 <= outstanding_nxt;
      if (pc_set_i) begin
        // Everything still in flight after this edge belongs to the old
        // stream, including a grant taken in this very cycle.
        fetch_addr_p0  <= branch_aligned;
        resp_pc_p0     <= branch_aligned;
        discard_cnt_p0 <= outstanding_nxt;
        rd_ptr_p0      <= '0;
        wr_ptr_p0      <= '0;
        count_p0       <= '0;
      end else begin
        if (fire) begin
          fetch_addr_p0 <= fetch_addr_p0 + 32'd4;
        end
        if (rsp && (discard_cnt_p0 != '0)) begin
          discard_cnt_p0 <= discard_cnt_p0 - CNT_W'(1);
        end
        if (push) begin
          resp_pc_p0 <= resp_pc_p0 + 32'd4;
          wr_ptr_p0  <= wr_ptr_p0 + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_p0 <= rd_ptr_p0 + PTR_W'(1);
        end
        count_p0 <= count_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_p0[wr_ptr_p0]    <= resp_pc_p0;
      fifo_instr_p0[wr_ptr_p0] <= instr_rdata_i;
    end
  end

  // ---- p1: IF/ID register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else if (pc_set_i) begin
      vld_p1 <= 1'b0;
    end else if (load) begin
      if (count_p0 != '0) begin
        vld_p1   <= 1'b1;
        pc_p1    <= fifo_pc_p0[rd_ptr_p0];
        instr_p1 <= fifo_instr_p0[rd_ptr_p0];
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (clear_instr_valid_i) begin
      vld_p1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cv32e40p_if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// Testbench for cv32e40p_if_prefetch_stage: directed vector table, hand
// sequences for redirect/halt/reset corners, and a randomized run checked
// against a stream-level reference model (per-redirect epochs, queues).
// ---------------------------------------------------------------------------
module tb_cv32e40p_if_prefetch_stage;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_set_i;
  logic [31:0] branch_addr_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        halt_if_i;
  logic        id_ready_i;
  logic        clear_instr_valid_i;
  logic        instr_valid_id_o;
  logic [31:0] instr_rdata_id_o;
  logic [31:0] pc_id_o;
  logic [2:0]  fifo_count_o;
  logic        busy_o;

  always #5 clk = ~clk;

  cv32e40p_if_prefetch_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .pc_set_i            (pc_set_i),
    .branch_addr_i       (branch_addr_i),
    .instr_req_o         (instr_req_o),
    .instr_addr_o        (instr_addr_o),
    .instr_gnt_i         (instr_gnt_i),
    .instr_rvalid_i      (instr_rvalid_i),
    .instr_rdata_i       (instr_rdata_i),
    .halt_if_i           (halt_if_i),
    .id_ready_i          (id_ready_i),
    .clear_instr_valid_i (clear_instr_valid_i),
    .instr_valid_id_o    (instr_valid_id_o),
    .instr_rdata_id_o    (instr_rdata_id_o),
    .pc_id_o             (pc_id_o),
    .fifo_count_o        (fifo_count_o),
    .busy_o              (busy_o)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  // Memory model: granted fetches waiting for their response, tagged with
  // the redirect epoch they were issued in.
  typedef struct {
    logic [31:0] addr;
    int          gcyc;
    int          epoch;
  } req_t;

  req_t        mq[$];
  logic [31:0] model_fifo[$];
  logic [31:0] stream_pc;
  logic [31:0] exp_req_addr;
  int          epoch;
  int          cyc;
  logic        prev_hold;
  logic [31:0] prev_addr;

  // Values seen just before the active edge of the last cycle
  logic        p_req, p_gnt, p_valid;
  logic [31:0] p_addr, p_pc, p_data;
  logic [2:0]  p_cnt;

  task automatic model_reset();
    mq.delete();
    model_fifo.delete();
    stream_pc    = 32'h80;
    exp_req_addr = 32'h80;
    epoch        = 0;
    cyc          = 0;
    prev_hold    = 1'b0;
    prev_addr    = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pc_set_i = 1'b0; branch_addr_i = 32'h0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; halt_if_i = 1'b0;
    id_ready_i = 1'b0; clear_instr_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive inputs, let the memory model grant/respond,
  // then update the reference model and compare after the edge.
  task automatic cycle(input logic halt, input logic idr, input logic pcs,
                       input logic [31:0] br, input logic clr,
                       input logic gen, input logic ren);
    req_t        h;
    logic        resp_now;
    logic [31:0] e;
    logic [31:0] al;
    halt_if_i = halt; id_ready_i = idr; pc_set_i = pcs;
    branch_addr_i = br; clear_instr_valid_i = clr;
    resp_now = ren && (mq.size() > 0) && (mq[0].gcyc < cyc);
    instr_rvalid_i = resp_now;
    instr_rdata_i  = resp_now ? memfn(mq[0].addr) : 32'h0;
    #1;
    instr_gnt_i = gen & instr_req_o;
    #1;
    p_req = instr_req_o; p_gnt = instr_gnt_i; p_addr = instr_addr_o;
    p_valid = instr_valid_id_o; p_pc = pc_id_o; p_data = instr_rdata_id_o;
    p_cnt = fifo_count_o;
    if (halt) check("req_low_in_halt", 32'(p_req), 32'd0);
    if (prev_hold && !halt) begin
      check("req_held_until_gnt", 32'(p_req), 32'd1);
      if (p_req) check("addr_stable", p_addr, prev_addr);
    end
    if (p_req && p_gnt) check("grant_addr", p_addr, exp_req_addr);
    @(posedge clk); #1;
    // reference model update
    if (resp_now) begin
      h = mq.pop_front();
      if (h.epoch == epoch && !pcs) begin
        model_fifo.push_front(32'h0);
        void'(model_fifo.pop_front());
      end
    end
    if (!pcs && halt == 1'b0 && idr) begin
      if (model_fifo.size() > 0) begin
        e = model_fifo.pop_front();
        check("id_valid_on_load", 32'(instr_valid_id_o), 32'd1);
        check("id_pc", pc_id_o, e);
        check("id_data", instr_rdata_id_o, memfn(e));
      end else begin
        check("id_valid_empty_load", 32'(instr_valid_id_o), 32'd0);
        check("id_pc_hold", pc_id_o, p_pc);
      end
    end else if (!pcs) begin
      check("id_valid_no_load", 32'(instr_valid_id_o), 32'(p_valid & ~clr));
      check("id_pc_hold", pc_id_o, p_pc);
      check("id_data_hold", instr_rdata_id_o, p_data);
    end
    if (resp_now && h.epoch == epoch && !pcs) begin
      model_fifo.push_back(stream_pc);
      stream_pc += 32'd4;
    end
    if (p_req && p_gnt) begin
      mq.push_back('{p_addr, cyc, epoch});
      exp_req_addr += 32'd4;
    end
    if (pcs) begin
      al = {br[31:2], 2'b00};
      check("id_valid_after_redirect", 32'(instr_valid_id_o), 32'd0);
      model_fifo.delete();
      stream_pc    = al;
      exp_req_addr = al;
      epoch++;
    end
    check("fifo_count", 32'(fifo_count_o), 32'(model_fifo.size()));
    check("no_overflow", 32'(fifo_count_o <= 3'(DEPTH)), 32'd1);
    check("outstanding_bound", 32'(mq.size() <= MAXO), 32'd1);
    check("busy", 32'(busy_o), 32'(mq.size() != 0));
    prev_hold = p_req & ~p_gnt & ~pcs;
    prev_addr = p_addr;
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
    cyc++;
  endtask

  typedef struct {
    logic        gen;
    logic        ren;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    int          exp_cnt;
  } vec_t;

  vec_t tv[7];

  initial begin
    tv[0] = '{1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h00, 0};
    tv[1] = '{1'b1, 1'b1, 1'b1, 32'h84, 1'b0, 32'h00, 0};
    tv[2] = '{1'b1, 1'b1, 1'b1, 32'h88, 1'b0, 32'h00, 1};
    tv[3] = '{1'b0, 1'b1, 1'b1, 32'h8C, 1'b1, 32'h80, 1};
    tv[4] = '{1'b0, 1'b0, 1'b1, 32'h8C, 1'b1, 32'h84, 1};
    tv[5] = '{1'b0, 1'b0, 1'b1, 32'h8C, 1'b1, 32'h88, 0};
    tv[6] = '{1'b0, 1'b0, 1'b1, 32'h8C, 1'b0, 32'h88, 0};

    // Reset state
    do_reset();
    rst = 1'b1; #1;
    check("rst_req", 32'(instr_req_o), 32'd0);
    check("rst_valid", 32'(instr_valid_id_o), 32'd0);
    check("rst_pc", pc_id_o, 32'd0);
    check("rst_data", instr_rdata_id_o, 32'd0);
    check("rst_count", 32'(fifo_count_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_addr", instr_addr_o, 32'h80);

    // 1: streaming fetch, table driven
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, tv[i].gen, tv[i].ren);
      check($sformatf("t1_req[%0d]", i), 32'(p_req), 32'(tv[i].exp_req));
      check($sformatf("t1_addr[%0d]", i), p_addr, tv[i].exp_addr);
      check($sformatf("t1_valid[%0d]", i), 32'(p_valid), 32'(tv[i].exp_valid));
      check($sformatf("t1_pc[%0d]", i), p_pc, tv[i].exp_pc);
      check($sformatf("t1_cnt[%0d]", i), 32'(p_cnt), 32'(tv[i].exp_cnt));
      if (tv[i].exp_valid) check($sformatf("t1_data[%0d]", i), p_data, memfn(tv[i].exp_pc));
    end

    // 2: ID stalled, FIFO fills, then drains in order
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("t2_full_count", 32'(fifo_count_o), 32'd4);
    check("t2_req_dropped", 32'(instr_req_o), 32'd0);
    check("t2_valid_low", 32'(instr_valid_id_o), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t2_last_pc", pc_id_o, 32'h8C);
    check("t2_last_valid", 32'(instr_valid_id_o), 32'd1);

    // 3: redirect with two fetches in flight
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h1003, 1'b0, 1'b1, 1'b0);
    check("t3_busy", 32'(busy_o), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("t3_new_req", 32'(p_req & p_gnt), 32'd1);
    check("t3_new_addr", p_addr, 32'h1000);
    check("t3_stale_dropped", 32'(fifo_count_o), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t3_pc", pc_id_o, 32'h1000);
    check("t3_data", instr_rdata_id_o, memfn(32'h1000));

    // 4: redirect coinciding with grant and response
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h2000, 1'b0, 1'b1, 1'b1);
    check("t4_granted_stale", 32'(p_req & p_gnt), 32'd1);
    check("t4_busy", 32'(busy_o), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("t4_new_addr", p_addr, 32'h2000);
    check("t4_count", 32'(fifo_count_o), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t4_pc", pc_id_o, 32'h2000);
    check("t4_data", instr_rdata_id_o, memfn(32'h2000));

    // 5: halt with one fetch outstanding
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("t5_req_low", 32'(p_req), 32'd0);
    check("t5_count", 32'(fifo_count_o), 32'd1);
    check("t5_valid_hold", 32'(instr_valid_id_o), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t5_valid_hold2", 32'(instr_valid_id_o), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check("t5_release_valid", 32'(instr_valid_id_o), 32'd1);
    check("t5_release_pc", pc_id_o, 32'h80);

    // 6: reset mid-operation
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    check("t6_pre_valid", 32'(instr_valid_id_o), 32'd1);
    check("t6_pre_busy", 32'(busy_o), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_req", 32'(instr_req_o), 32'd0);
    check("t6_valid", 32'(instr_valid_id_o), 32'd0);
    check("t6_pc", pc_id_o, 32'd0);
    check("t6_data", instr_rdata_id_o, 32'd0);
    check("t6_count", 32'(fifo_count_o), 32'd0);
    check("t6_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    halt_if_i = 1'b1;
    instr_rvalid_i = 1'b1;
    instr_rdata_i = memfn(32'h8C);
    @(posedge clk); #1;
    instr_rvalid_i = 1'b0;
    check("t6_stray_count", 32'(fifo_count_o), 32'd0);
    check("t6_stray_busy", 32'(busy_o), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("t6_restart_req", 32'(p_req & p_gnt), 32'd1);
    check("t6_restart_addr", p_addr, 32'h80);

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 19) == 0),
            $urandom,
            ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 9) < 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
